window_stats_unit: RTL



---
 rtl/wsu_pkg.sv | 33 +++
 rtl/wsu_stat_update.sv | 27 ++
 rtl/window_stats_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/wsu_pkg.sv
// Shared types and defaults for the window statistics unit.
package wsu_pkg;

    localparam int DATA_W_DEF  = 12;
    localparam int WIN_LEN_DEF = 8;
    localparam int SUM_W_DEF   = 15;

    // ACCUM collects samples; HOLD presents a finished window result.
    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } wsu_state_e;

    // Running statistics of the window currently being collected.
    typedef struct packed {
        logic [SUM_W_DEF-1:0]  sum;
        logic [DATA_W_DEF-1:0] min;
        logic [DATA_W_DEF-1:0] max;
        logic [DATA_W_DEF-1:0] xor_fold;
    } wsu_acc_t;

    // Accumulator value at the start of a window: min starts at all-ones
    // so the first sample always replaces it.
    function automatic wsu_acc_t acc_init();
        wsu_acc_t a;
        a.sum      = {SUM_W_DEF{1'b0}};
        a.min      = {DATA_W_DEF{1'b1}};
        a.max      = {DATA_W_DEF{1'b0}};
        a.xor_fold = {DATA_W_DEF{1'b0}};
        return a;
    endfunction

endpackage

// File: rtl/wsu_stat_update.sv
// Combinational next-accumulator: folds one sample into the running stats.
module wsu_stat_update
    import wsu_pkg::*;
(
    input  wsu_acc_t                cur_acc,
    input  logic [DATA_W_DEF-1:0]   sample,
    output wsu_acc_t                nxt_acc
);

    // Sum, unsigned min/max (ties keep the stored value) and XOR fold.
    always_comb begin
        nxt_acc          = cur_acc;
        nxt_acc.sum      = cur_acc.sum + SUM_W_DEF'(sample);
        nxt_acc.xor_fold = cur_acc.xor_fold ^ sample;
        if (sample < cur_acc.min) begin
            nxt_acc.min = sample;
        end else begin
            nxt_acc.min = cur_acc.min;
        end
        if (sample > cur_acc.max) begin
            nxt_acc.max = sample;
        end else begin
            nxt_acc.max = cur_acc.max;
        end
    end

endmodule

// File: rtl/window_stats_unit.sv
// Window statistics unit: accumulates WIN_LEN samples, then holds the
// sum/min/max/xor result until the consumer accepts it.
module window_stats_unit
    import wsu_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int SUM_W   = SUM_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_min,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_xor
);

    localparam int CNT_W = $clog2(WIN_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);

    wsu_state_e         state_r;
    wsu_state_e         state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    wsu_acc_t           acc_r;
    wsu_acc_t           nxt_acc_s;
    logic [DATA_W_DEF-1:0] sample_s;
    logic               accept_s;
    logic               last_s;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [SUM_W-1:0]   out_sum_r;
    logic [DATA_W-1:0]  out_min_r;
    logic [DATA_W-1:0]  out_max_r;
    logic [DATA_W-1:0]  out_xor_r;

    assign sample_s  = DATA_W_DEF'(in_data);
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_sum   = out_sum_r;
    assign out_min   = out_min_r;
    assign out_max   = out_max_r;
    assign out_xor   = out_xor_r;

    wsu_stat_update u_stat_update (
        .cur_acc (acc_r),
        .sample  (sample_s),
        .nxt_acc (nxt_acc_s)
    );

    // Next-state decode; a sample coinciding with clear is discarded.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        last_s      = 1'b0;
        case (state_r)
            ACCUM: begin
                accept_s = in_valid & ~clear;
                if (accept_s && (cnt_r == CNT_LAST)) begin
                    last_s      = 1'b1;
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = ACCUM;
            end
        endcase
    end

    // State register with registered handshake flags decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ACCUM;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == ACCUM);
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

    // Counter, accumulators and result registers; results persist after handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= acc_init();
            out_sum_r <= {SUM_W{1'b0}};
            out_min_r <= {DATA_W{1'b0}};
            out_max_r <= {DATA_W{1'b0}};
            out_xor_r <= {DATA_W{1'b0}};
        end else if ((state_r == ACCUM) && clear) begin
            cnt_r <= {CNT_W{1'b0}};
            acc_r <= acc_init();
        end else if (last_s) begin
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= acc_init();
            out_sum_r <= SUM_W'(nxt_acc_s.sum);
            out_min_r <= DATA_W'(nxt_acc_s.min);
            out_max_r <= DATA_W'(nxt_acc_s.max);
            out_xor_r <= DATA_W'(nxt_acc_s.xor_fold);
        end else if (accept_s) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            acc_r <= nxt_acc_s;
        end
    end

endmodule
